// File: rtl/frame_window_capture.sv
// frame_window_capture: copies a rectangular window of one colour
// channel (or luma) from the pixel stream into a linear word memory.
module frame_window_capture #(
    parameter int H_START     = 320,
    parameter int V_START     = 240,
    parameter int H_RES       = 160,
    parameter int V_RES       = 120,
    parameter int ADDR_W      = 15,
    parameter int PIX_W       = 10,
    parameter int SKIP_FRAMES = 5
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic [9:0]        iRed,
    input  logic [9:0]        iGreen,
    input  logic [9:0]        iBlue,
    input  logic [12:0]       iX,
    input  logic [12:0]       iY,
    input  logic              iVal,
    input  logic              iStart,
    input  logic              iAck,
    input  logic              iMode,
    input  logic [1:0]        iChanSel,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic [PIX_W-1:0]  oMemData,
    output logic              oMemWE,
    output logic              oReady,
    output logic              oBusy,
    output logic              oStopCapture,
    output logic [7:0]        oFrameCount,
    output logic              oLed
);

    typedef enum logic [1:0] {IDLE, WAIT, CAP, DONE} state_t;

    // Bounds kept one bit wider than the coordinates so H_START+H_RES
    // cannot wrap.
    localparam logic [13:0] X_LO   = 14'(H_START);
    localparam logic [13:0] X_HI   = 14'(H_START + H_RES);
    localparam logic [13:0] X_LAST = 14'(H_START + H_RES - 1);
    localparam logic [13:0] Y_LO   = 14'(V_START);
    localparam logic [13:0] Y_HI   = 14'(V_START + V_RES);
    localparam logic [13:0] Y_LAST = 14'(V_START + V_RES - 1);

    state_t      state;
    logic [7:0]  skipCnt;
    logic        modeReg;
    logic [1:0]  chanReg;

    logic [13:0]       xExt;
    logic [13:0]       yExt;
    logic              origin;
    logic              inWin;
    logic              lastPix;
    logic [12:0]       dx;
    logic [12:0]       dy;
    logic [ADDR_W-1:0] pixAddr;
    logic [11:0]       lumaSum;
    logic [9:0]        chanVal;
    logic [PIX_W-1:0]  pixData;

    assign xExt    = {1'b0, iX};
    assign yExt    = {1'b0, iY};
    assign origin  = iVal && (xExt == X_LO) && (yExt == Y_LO);
    assign inWin   = iVal && (xExt >= X_LO) && (xExt < X_HI)
                          && (yExt >= Y_LO) && (yExt < Y_HI);
    assign lastPix = inWin && (xExt == X_LAST) && (yExt == Y_LAST);

    // Window-relative offsets; row stride is the window width.
    assign dx      = iX - 13'(H_START);
    assign dy      = iY - 13'(V_START);
    assign pixAddr = ADDR_W'(dy) * ADDR_W'(H_RES) + ADDR_W'(dx);

    assign lumaSum = {2'b00, iRed} + {1'b0, iGreen, 1'b0} + {2'b00, iBlue};

    // Channel selection uses the mode latched at arm time.
    always_comb begin
        chanVal = iRed;
        case (chanReg)
            2'd0:    chanVal = iRed;
            2'd1:    chanVal = iGreen;
            2'd2:    chanVal = iBlue;
            default: chanVal = 10'(lumaSum >> 2);
        endcase
    end

    assign pixData = PIX_W'(chanVal >> (10 - PIX_W));

    // Capture FSM with all outputs registered.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state        <= IDLE;
            skipCnt      <= '0;
            modeReg      <= 1'b0;
            chanReg      <= '0;
            oMemAddr     <= '0;
            oMemData     <= '0;
            oMemWE       <= 1'b0;
            oReady       <= 1'b0;
            oBusy        <= 1'b0;
            oStopCapture <= 1'b0;
            oFrameCount  <= '0;
            oLed         <= 1'b0;
        end else begin
            oMemWE <= 1'b0;
            if (origin)
                oFrameCount <= oFrameCount + 8'd1;
            unique case (state)
                IDLE: begin
                    if (iStart) begin
                        state   <= WAIT;
                        skipCnt <= 8'(SKIP_FRAMES);
                        modeReg <= iMode;
                        chanReg <= iChanSel;
                        oBusy   <= 1'b1;
                        oLed    <= 1'b1;
                    end
                end
                WAIT: begin
                    if (origin) begin
                        if (skipCnt == 8'd0) begin
                            oMemWE   <= 1'b1;
                            oMemAddr <= pixAddr;
                            oMemData <= pixData;
                            state    <= CAP;
                            if (lastPix) begin
                                state        <= DONE;
                                oReady       <= 1'b1;
                                oStopCapture <= ~modeReg;
                                oBusy        <= 1'b0;
                                oLed         <= 1'b0;
                            end
                        end else begin
                            skipCnt <= skipCnt - 8'd1;
                        end
                    end
                end
                CAP: begin
                    if (inWin) begin
                        oMemWE   <= 1'b1;
                        oMemAddr <= pixAddr;
                        oMemData <= pixData;
                        if (lastPix) begin
                            state        <= DONE;
                            oReady       <= 1'b1;
                            oStopCapture <= ~modeReg;
                            oBusy        <= 1'b0;
                            oLed         <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (iStart) begin
                        state        <= WAIT;
                        skipCnt      <= 8'(SKIP_FRAMES);
                        modeReg      <= iMode;
                        chanReg      <= iChanSel;
                        oReady       <= 1'b0;
                        oStopCapture <= 1'b0;
                        oBusy        <= 1'b1;
                        oLed         <= 1'b1;
                    end else if (iAck) begin
                        state        <= IDLE;
                        oReady       <= 1'b0;
                        oStopCapture <= 1'b0;
                    end else if (modeReg && origin) begin
                        state    <= CAP;
                        oReady   <= 1'b0;
                        oBusy    <= 1'b1;
                        oLed     <= 1'b1;
                        oMemWE   <= 1'b1;
                        oMemAddr <= pixAddr;
                        oMemData <= pixData;
                        if (lastPix) begin
                            state  <= DONE;
                            oReady <= 1'b1;
                            oBusy  <= 1'b0;
                            oLed   <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
